// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: random mole selection from a 16-bit LFSR,
// shrinking up-time after each hit, win/lose display when the game ends.
module mole_game_ctrl #(
  parameter int          N_HOLES   = 10,
  parameter int          ROUNDS    = 4,
  parameter int          UP_CYCLES = 1000,
  parameter int          MIN_UP    = 16,
  parameter int          WIN_HITS  = 3,
  parameter bit          SPEEDUP   = 1'b1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic [1:0]         KEY,
  input  logic [N_HOLES-1:0] SW,
  output logic [N_HOLES-1:0] LEDR,
  output logic [2:0]         state,
  output logic [7:0]         times,
  output logic [7:0]         score,
  output logic               win,
  output logic               enable
);

  localparam int IDX_W = $clog2(N_HOLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_UP    = 3'd2,
    S_HIT   = 3'd3,
    S_MISS  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               key_rst;
  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [1:0]         key_sync;
  logic               key_prev;
  logic               press;
  logic [15:0]        lfsr_q;
  logic               lfsr_fb;
  logic [19:0]        up_time_q;
  logic [19:0]        timer_q;
  logic [19:0]        shrunk_time;
  logic [19:0]        next_up_time;
  logic [IDX_W-1:0]   mole_q;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   spawn_idx;
  logic [N_HOLES-1:0] mole_hot;
  logic [7:0]         score_q;
  logic [7:0]         times_q;
  logic [7:0]         times_inc;
  logic               done_win;

  // Reset asserts immediately but is released on a clock edge.
  assign key_rst = KEY[1];
  always_ff @(posedge clk or negedge key_rst) begin
    if (!key_rst) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync <= 2'b11;
      key_prev <= 1'b1;
      lfsr_q   <= SEED;
    end else begin
      key_sync <= {key_sync[0], KEY[0]};
      key_prev <= key_sync[1];
      lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign press   = !key_sync[1] && key_prev;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A repeat of the previous hole is bumped to the next hole.
  assign cand = IDX_W'(lfsr_q % 16'(N_HOLES));
  always_comb begin
    spawn_idx = cand;
    if (cand == mole_q)
      spawn_idx = (cand == IDX_W'(N_HOLES - 1)) ? '0 : cand + IDX_W'(1);
  end

  assign mole_hot     = {{(N_HOLES-1){1'b0}}, 1'b1} << mole_q;
  assign shrunk_time  = up_time_q - (up_time_q >> 3);
  assign next_up_time = (shrunk_time < 20'(MIN_UP)) ? 20'(MIN_UP) : shrunk_time;
  assign times_inc    = times_q + 8'd1;
  assign done_win     = (score_q >= 8'(WIN_HITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (press) state_d = S_SPAWN;
      S_SPAWN: state_d = S_UP;
      S_UP: begin
        if (press)              state_d = (SW == mole_hot) ? S_HIT : S_MISS;
        else if (timer_q == '0) state_d = S_MISS;
      end
      S_HIT, S_MISS: state_d = (times_inc == 8'(ROUNDS)) ? S_DONE : S_SPAWN;
      S_DONE:  if (press) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q   <= '0;
      times_q   <= '0;
      up_time_q <= 20'(UP_CYCLES);
      timer_q   <= '0;
      mole_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          score_q   <= '0;
          times_q   <= '0;
          up_time_q <= 20'(UP_CYCLES);
        end
        S_SPAWN: begin
          mole_q  <= spawn_idx;
          timer_q <= up_time_q;
        end
        S_UP: if (timer_q != '0) timer_q <= timer_q - 20'd1;
        S_HIT: begin
          score_q <= score_q + 8'd1;
          times_q <= times_inc;
          if (SPEEDUP) up_time_q <= next_up_time;
        end
        S_MISS:  times_q <= times_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    LEDR   = '0;
    win    = 1'b0;
    enable = 1'b0;
    if (state_q == S_UP) begin
      LEDR   = mole_hot;
      enable = 1'b1;
    end else if (state_q == S_DONE) begin
      win  = done_win;
      LEDR = done_win ? '1 : '0;
    end
  end

  assign state = state_q;
  assign times = times_q;
  assign score = score_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with short up-times; outputs sampled on the falling edge.
module tb_mole_game_ctrl;

  logic       clk;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [2:0] state;
  logic [7:0] times;
  logic [7:0] score;
  logic       win;
  logic       enable;

  int checks = 0;
  int errors = 0;

  mole_game_ctrl #(
    .N_HOLES(10), .ROUNDS(4), .UP_CYCLES(16), .MIN_UP(8), .WIN_HITS(3),
    .SPEEDUP(1'b1), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .KEY(key), .SW(sw), .LEDR(ledr), .state(state),
    .times(times), .score(score), .win(win), .enable(enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns two falling edges later with the key released.
  task automatic press_key(input logic [9:0] s);
    sw     = s;
    key[0] = 1'b0;
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_game(output bit ok);
    press_key(10'h000);
    wait_state(3'd2, 4, ok);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    key[1] = 1'b0;
    repeat (2) @(negedge clk);
    key[1] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    key = 2'b11;
    sw  = '0;
    repeat (3) @(negedge clk);
    key[1] = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || ledr !== 10'h000 || times !== 8'd0 || score !== 8'd0 ||
        win !== 1'b0 || enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: state=%0d ledr=%h times=%0d score=%0d win=%b en=%b want all zero",
               state, ledr, times, score, win, enable);
    end
    repeat (3) @(negedge clk);
    key[1] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd0 || ledr !== 10'h000) begin
      errors++;
      $display("FAIL reset_release: state=%0d ledr=%h want 0 000", state, ledr);
    end
  endtask

  task automatic test_start();
    sw     = '0;
    key[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL start_n1: state=%0d want 0", state); end
    @(negedge clk);
    key[0] = 1'b1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL start_n2: state=%0d want 0", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL start_spawn: state=%0d want 1", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || enable !== 1'b1 || !$onehot(ledr)) begin
      errors++;
      $display("FAIL start_up: state=%0d en=%b ledr=%h want 2 1 one-hot", state, enable, ledr);
    end
  endtask

  // Continues the game left in UP by test_start.
  task automatic test_whack();
    bit         ok;
    logic [9:0] prev;
    prev = '0;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        wait_state(3'd2, 4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL whack_up_r%0d: state=%0d want 2", r, state); end
        checks++;
        if (!$onehot(ledr) || ledr === prev) begin
          errors++;
          $display("FAIL whack_mole_r%0d: ledr=%h prev=%h want new one-hot", r, ledr, prev);
        end
      end
      prev = ledr;
      press_key(ledr);
      @(negedge clk);
      checks++;
      if (state !== 3'd3) begin errors++; $display("FAIL whack_hit_r%0d: state=%0d want 3", r, state); end
      @(negedge clk);
      checks++;
      if (score !== 8'(r + 1) || times !== 8'(r + 1)) begin
        errors++;
        $display("FAIL whack_count_r%0d: score=%0d times=%0d want %0d", r, score, times, r + 1);
      end
    end
    checks++;
    if (state !== 3'd5 || win !== 1'b1 || ledr !== 10'h3FF || enable !== 1'b0) begin
      errors++;
      $display("FAIL whack_done: state=%0d win=%b ledr=%h en=%b want 5 1 3ff 0", state, win, ledr, enable);
    end
    press_key(10'h000);
    wait_state(3'd0, 4, ok);
    @(negedge clk);
    checks++;
    if (!ok || score !== 8'd0 || times !== 8'd0 || ledr !== 10'h000 || win !== 1'b0) begin
      errors++;
      $display("FAIL whack_idle: ok=%b score=%0d times=%0d ledr=%h win=%b want 1 0 0 000 0",
               ok, score, times, ledr, win);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    start_game(ok);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) wait_state(3'd2, 4, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL timeout_up_r%0d: state=%0d want 2", r, state); end
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (state !== 3'd2) break;
        cnt++;
      end
      checks++;
      if (cnt != 17 || state !== 3'd4) begin
        errors++;
        $display("FAIL timeout_len_r%0d: cycles=%0d state=%0d want 17 4", r, cnt, state);
      end
      @(negedge clk);
      checks++;
      if (times !== 8'(r + 1) || score !== 8'd0) begin
        errors++;
        $display("FAIL timeout_count_r%0d: times=%0d score=%0d want %0d 0", r, times, score, r + 1);
      end
    end
    checks++;
    if (state !== 3'd5 || win !== 1'b0 || ledr !== 10'h000 || score !== 8'd0) begin
      errors++;
      $display("FAIL timeout_done: state=%0d win=%b ledr=%h score=%0d want 5 0 000 0", state, win, ledr, score);
    end
  endtask

  // Holding the key from DONE must produce a single event: back to IDLE, never on to SPAWN.
  task automatic test_hold_press();
    int spawn_cnt;
    spawn_cnt = 0;
    key[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state === 3'd1) spawn_cnt++;
    end
    checks++;
    if (state !== 3'd0 || spawn_cnt != 0) begin
      errors++;
      $display("FAIL hold_press: state=%0d spawns=%0d want 0 0", state, spawn_cnt);
    end
    key[0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL hold_release: state=%0d want 0", state); end
  endtask

  task automatic test_speedup();
    bit ok;
    int cnt;
    int exp_len[4] = '{0, 15, 0, 14};
    start_game(ok);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) wait_state(3'd2, 4, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL speed_up_r%0d: state=%0d want 2", r, state); end
      if (r % 2 == 0) begin
        press_key(ledr);
        @(negedge clk);
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL speed_hit_r%0d: state=%0d want 3", r, state); end
      end else begin
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (state !== 3'd2) break;
          cnt++;
        end
        checks++;
        if (cnt != exp_len[r] || state !== 3'd4) begin
          errors++;
          $display("FAIL speed_len_r%0d: cycles=%0d state=%0d want %0d 4", r, cnt, state, exp_len[r]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd5 || score !== 8'd2 || times !== 8'd4 || win !== 1'b0 || ledr !== 10'h000) begin
      errors++;
      $display("FAIL speed_done: state=%0d score=%0d times=%0d win=%b ledr=%h want 5 2 4 0 000",
               state, score, times, win, ledr);
    end
    press_key(10'h000);
    wait_state(3'd0, 4, ok);
  endtask

  task automatic test_bad_press();
    bit         ok;
    logic [9:0] s;
    start_game(ok);
    for (int r = 0; r < 3; r++) begin
      if (r > 0) wait_state(3'd2, 4, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bad_up_r%0d: state=%0d want 2", r, state); end
      if (r == 0)      s = (ledr == 10'h001) ? 10'h002 : 10'h001;
      else if (r == 1) s = 10'h000;
      else             s = ledr | ((ledr == 10'h200) ? 10'h001 : 10'h200);
      press_key(s);
      @(negedge clk);
      checks++;
      if (state !== 3'd4) begin errors++; $display("FAIL bad_miss_r%0d: state=%0d want 4", r, state); end
      @(negedge clk);
      checks++;
      if (score !== 8'd0 || times !== 8'(r + 1)) begin
        errors++;
        $display("FAIL bad_count_r%0d: score=%0d times=%0d want 0 %0d", r, score, times, r + 1);
      end
    end
    wait_state(3'd2, 4, ok);
    s = ledr;
    repeat (14) @(negedge clk);
    press_key(s);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL deadline_still_up: state=%0d want 2", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL deadline_hit: state=%0d want 3", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd5 || score !== 8'd1 || times !== 8'd4 || win !== 1'b0) begin
      errors++;
      $display("FAIL bad_done: state=%0d score=%0d times=%0d win=%b want 5 1 4 0", state, score, times, win);
    end
    press_key(10'h000);
    wait_state(3'd0, 4, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cnt;
    start_game(ok);
    for (int r = 0; r < 2; r++) begin
      if (r > 0) wait_state(3'd2, 4, ok);
      press_key(ledr);
    end
    wait_state(3'd2, 6, ok);
    checks++;
    if (!ok || times !== 8'd2 || score !== 8'd2) begin
      errors++;
      $display("FAIL mid_round3: ok=%b times=%0d score=%0d want 1 2 2", ok, times, score);
    end
    repeat (3) @(negedge clk);
    #2 key[1] = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || ledr !== 10'h000 || times !== 8'd0 || score !== 8'd0 ||
        win !== 1'b0 || enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d ledr=%h times=%0d score=%0d win=%b en=%b want all zero",
               state, ledr, times, score, win, enable);
    end
    @(negedge clk);
    key[1] = 1'b1;
    repeat (3) @(negedge clk);
    start_game(ok);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state !== 3'd2) break;
      cnt++;
    end
    checks++;
    if (!ok || cnt != 17) begin
      errors++;
      $display("FAIL mid_restart_len: ok=%b cycles=%0d want 1 17", ok, cnt);
    end
    @(negedge clk);
    checks++;
    if (times !== 8'd1 || score !== 8'd0) begin
      errors++;
      $display("FAIL mid_restart_count: times=%0d score=%0d want 1 0", times, score);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    press_key(10'h000);
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL wrap_spawn1: state=%0d want 1", state); end
    force dut.lfsr_q = 16'd9;
    @(negedge clk);
    release dut.lfsr_q;
    checks++;
    if (state !== 3'd2 || ledr !== 10'h200) begin
      errors++;
      $display("FAIL wrap_mole9: state=%0d ledr=%h want 2 200", state, ledr);
    end
    press_key(10'h200);
    wait_state(3'd1, 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_spawn2: state=%0d want 1", state); end
    force dut.lfsr_q = 16'd19;
    @(negedge clk);
    release dut.lfsr_q;
    checks++;
    if (state !== 3'd2 || ledr !== 10'h001) begin
      errors++;
      $display("FAIL wrap_mole0: state=%0d ledr=%h want 2 001", state, ledr);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_start();
    test_whack();
    test_timeout();
    test_hold_press();
    test_speedup();
    test_bad_press();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
